// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Latency: none (wires only); response is same-cycle with imem_ready.
// Backpressure: imem_ready low holds the request; the master keeps imem_addr stable.
//
// Ports (master = fetch stage, slave = instruction memory):
//   imem_req    master->slave  request valid
//   imem_addr   master->slave  word-aligned request address
//   imem_ready  slave->master  imem_data valid for the current request
//   imem_data   slave->master  instruction word
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, requests imem, drives the IF/ID bundle and its flush.
// Latency: same-cycle delivery when imem_ready=1; a redirect target appears 1 cycle later.
// Backpressure: stall parks a delivered word in HOLD (imem_req=0); imem_ready=0 keeps REQ.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   stall               IF/ID holding; the delivered instruction is not consumed
//   redirect/_pc        taken branch/jump; target low two bits are forced to 0
//   imem                master side of the instruction-memory handshake
//   pc                  registered fetch PC
//   if_id_out           {pc+4, instruction}, nextPC in the upper 32 bits
//   if_id_flush         IF/ID captures a bubble; instruction field is NOP_INSTR
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             pc,
  output logic [63:0]             if_id_out,
  output logic                    if_id_flush
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] hold_instr;
  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic [31:0] out_instr;

  assign pc_plus4  = pc + 32'd4;             // wraps mod 2^32
  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else if (redirect) begin
      pc <= redir_tgt;
      // An outstanding, unanswered request cannot be withdrawn: keep its address
      // on the bus and discard its data in DROP. Later redirects only move pc.
      if ((state == S_REQ || state == S_DROP) && !imem.imem_ready) begin
        state <= S_DROP;
      end else begin
        req_addr <= redir_tgt;
        state    <= S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: begin
          req_addr <= pc;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (imem.imem_ready) begin
            if (stall) begin
              hold_instr <= imem.imem_data;
              state      <= S_HOLD;
            end else begin
              pc       <= pc_plus4;
              req_addr <= pc_plus4;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc       <= pc_plus4;
            req_addr <= pc_plus4;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          // Stale data returns now; re-issue at the redirected pc.
          if (imem.imem_ready) begin
            req_addr <= pc;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delivery is combinational so a ready word reaches IF/ID in its own cycle.
  always_comb begin
    if_id_flush = 1'b1;
    out_instr   = NOP_INSTR;
    if (!redirect) begin
      case (state)
        S_REQ: begin
          if (imem.imem_ready) begin
            if_id_flush = 1'b0;
            out_instr   = imem.imem_data;
          end
        end
        S_HOLD: begin
          if_id_flush = 1'b0;
          out_instr   = hold_instr;
        end
        default: ;
      endcase
    end
  end

  assign if_id_out      = {pc_plus4, out_instr};
  assign imem.imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem.imem_addr = req_addr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: vector table driven on negedge, sampled before posedge.
// Latency: each row checks the same-cycle outputs of the inputs it applies.
// Backpressure: memory wait states and stalls come from the table itself.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [63:0] if_id_out;
  logic        if_id_flush;

  if_fetch_stage_if mem ();

  if_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (mem),
    .pc         (pc),
    .if_id_out  (if_id_out),
    .if_id_flush(if_id_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] dat;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_fl;
    logic [31:0] e_next;
    logic [31:0] e_ins;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];
  vec_t sb [$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(
    input logic st, input logic rd, input logic [31:0] rpc,
    input logic rdy, input logic [31:0] dat,
    input logic req, input logic [31:0] addr, input logic [31:0] epc,
    input logic fl, input logic [31:0] nxt, input logic [31:0] ins);
    vec_t v;
    v.stall = st;  v.redir = rd;  v.rpc = rpc;  v.rdy = rdy;  v.dat = dat;
    v.e_req = req; v.e_addr = addr; v.e_pc = epc; v.e_fl = fl;
    v.e_next = nxt; v.e_ins = ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req"},   {63'd0, mem.imem_req}, 64'd0);
    chk({tag, " addr"},  {32'd0, mem.imem_addr}, 64'd0);
    chk({tag, " pc"},    {32'd0, pc}, 64'd0);
    chk({tag, " flush"}, {63'd0, if_id_flush}, 64'd1);
    chk({tag, " out"},   if_id_out, {32'h0000_0004, 32'h0000_0000});
  endtask

  // Called at a negedge: drive, queue expectation, sample 2 units later, advance.
  task automatic run_row(input int i);
    vec_t e;
    stall          = vt[i].stall;
    redirect       = vt[i].redir;
    redirect_pc    = vt[i].rpc;
    mem.imem_ready = vt[i].rdy;
    mem.imem_data  = vt[i].dat;
    sb.push_back(vt[i]);
    #2;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL row%0d scoreboard empty: got 0 entries want 1", i);
    end else begin
      e = sb.pop_front();
      chk($sformatf("row%0d req", i),   {63'd0, mem.imem_req}, {63'd0, e.e_req});
      chk($sformatf("row%0d addr", i),  {32'd0, mem.imem_addr}, {32'd0, e.e_addr});
      chk($sformatf("row%0d pc", i),    {32'd0, pc}, {32'd0, e.e_pc});
      chk($sformatf("row%0d flush", i), {63'd0, if_id_flush}, {63'd0, e.e_fl});
      chk($sformatf("row%0d out", i),   if_id_out, {e.e_next, e.e_ins});
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Phase 1: straight-line fetch with a zero-wait memory.
    //              st rd rpc           rdy dat            req addr          pc            fl next          ins
    vt[0]  = mk(0, 0, 32'h0,        1, 32'h0000_0001, 0, 32'h0,        32'h0,        1, 32'h4,        32'h0);
    vt[1]  = mk(0, 0, 32'h0,        1, 32'hA000_0000, 1, 32'h0,        32'h0,        0, 32'h4,        32'hA000_0000);
    vt[2]  = mk(0, 0, 32'h0,        1, 32'hA000_0004, 1, 32'h4,        32'h4,        0, 32'h8,        32'hA000_0004);
    vt[3]  = mk(0, 0, 32'h0,        1, 32'hA000_0008, 1, 32'h8,        32'h8,        0, 32'hC,        32'hA000_0008);
    // Phase 2: wait states, stall/HOLD, redirect into DROP, redirect during stall,
    // misaligned redirect, pc wrap, and back-to-back redirects while dropping.
    vt[4]  = mk(0, 0, 32'h0,        1, 32'h0000_0001, 0, 32'h0,        32'h0,        1, 32'h4,        32'h0);
    vt[5]  = mk(0, 0, 32'h0,        1, 32'h0000_0013, 1, 32'h0,        32'h0,        0, 32'h4,        32'h0000_0013);
    vt[6]  = mk(0, 0, 32'h0,        0, 32'h1111_1111, 1, 32'h4,        32'h4,        1, 32'h8,        32'h0);
    vt[7]  = mk(0, 0, 32'h0,        0, 32'h2222_2222, 1, 32'h4,        32'h4,        1, 32'h8,        32'h0);
    vt[8]  = mk(0, 0, 32'h0,        1, 32'h0040_0093, 1, 32'h4,        32'h4,        0, 32'h8,        32'h0040_0093);
    vt[9]  = mk(1, 0, 32'h0,        1, 32'h20A3_0004, 1, 32'h8,        32'h8,        0, 32'hC,        32'h20A3_0004);
    vt[10] = mk(1, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h8,        32'h8,        0, 32'hC,        32'h20A3_0004);
    vt[11] = mk(1, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h8,        32'h8,        0, 32'hC,        32'h20A3_0004);
    vt[12] = mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h8,        32'h8,        0, 32'hC,        32'h20A3_0004);
    vt[13] = mk(0, 1, 32'h100,      0, 32'h3333_3333, 1, 32'hC,        32'hC,        1, 32'h10,       32'h0);
    vt[14] = mk(0, 0, 32'h0,        0, 32'h4444_4444, 1, 32'hC,        32'h100,      1, 32'h104,      32'h0);
    vt[15] = mk(0, 0, 32'h0,        1, 32'hBAD0_0BAD, 1, 32'hC,        32'h100,      1, 32'h104,      32'h0);
    vt[16] = mk(1, 0, 32'h0,        1, 32'h0010_0113, 1, 32'h100,      32'h100,      0, 32'h104,      32'h0010_0113);
    vt[17] = mk(1, 1, 32'h203,      1, 32'h5555_5555, 0, 32'h100,      32'h100,      1, 32'h104,      32'h0);
    vt[18] = mk(0, 0, 32'h0,        1, 32'h0020_0213, 1, 32'h200,      32'h200,      0, 32'h204,      32'h0020_0213);
    vt[19] = mk(0, 1, 32'h103,      1, 32'h0000_1234, 1, 32'h204,      32'h204,      1, 32'h208,      32'h0);
    vt[20] = mk(0, 0, 32'h0,        1, 32'h0030_0313, 1, 32'h100,      32'h100,      0, 32'h104,      32'h0030_0313);
    vt[21] = mk(0, 1, 32'hFFFF_FFFF, 1, 32'h6666_6666, 1, 32'h104,     32'h104,      1, 32'h108,      32'h0);
    vt[22] = mk(0, 0, 32'h0,        1, 32'h0040_0413, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,      32'h0040_0413);
    vt[23] = mk(0, 0, 32'h0,        0, 32'h7777_7777, 1, 32'h0,        32'h0,        1, 32'h4,        32'h0);
    vt[24] = mk(0, 1, 32'h300,      0, 32'h8888_8888, 1, 32'h0,        32'h0,        1, 32'h4,        32'h0);
    vt[25] = mk(0, 1, 32'h400,      0, 32'h9999_9999, 1, 32'h0,        32'h300,      1, 32'h304,      32'h0);
    vt[26] = mk(0, 0, 32'h0,        1, 32'hBAD1_1BAD, 1, 32'h0,        32'h400,      1, 32'h404,      32'h0);
    vt[27] = mk(0, 0, 32'h0,        1, 32'h0050_0513, 1, 32'h400,      32'h400,      0, 32'h404,      32'h0050_0513);

    reset          = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    mem.imem_ready = 1'b0;
    mem.imem_data  = 32'h0;
    repeat (2) @(negedge clk);
    #1 chk_reset("por");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) run_row(i);

    // Reset mid-request with a late ready: outputs must drop before any clock edge.
    mem.imem_ready = 1'b1;
    mem.imem_data  = 32'hCAFE_F00D;
    #1 reset = 1'b0;
    #2 chk_reset("midreq");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 4; i < NV; i++) run_row(i);

    // Reset again from a non-zero pc with a request outstanding.
    mem.imem_ready = 1'b0;
    #1 reset = 1'b0;
    #2 chk_reset("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
